// File: rtl/alg_amba_vip_base_delayline_prog.sv
// rtl/alg_amba_vip_base_delayline_prog.sv - programmable per-beat delay line with in-order release
// Beats queue with a delay counter each; only the head may leave, and only once its counter hits zero.
module alg_amba_vip_base_delayline_prog #(
   parameter int DATA_WIDTH       = 16,
   parameter int DEPTH_LOG2       = 6,
   parameter int DELAY_WIDTH      = 11,
   parameter int TABLE_LOG2_DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [1:0]             cfg_mode,
   input  logic [DELAY_WIDTH-1:0] cfg_fixed_delay,
   input  logic [DEPTH_LOG2:0]    cfg_max_outst,
   input  logic [DELAY_WIDTH-1:0] distr_value,
   input  logic                   distr_write,
   input  logic                   distr_rstptr,
   input  logic [15:0]            distr_seed,
   input  logic                   s_valid,
   input  logic [DATA_WIDTH-1:0]  s_data,
   output logic                   s_ready,
   output logic                   m_valid,
   output logic [DATA_WIDTH-1:0]  m_data,
   input  logic                   m_ready,
   output logic [DEPTH_LOG2:0]    outstanding
);
   localparam int DEPTH  = 1 << DEPTH_LOG2;
   localparam int TDEPTH = 1 << TABLE_LOG2_DEPTH;
   localparam logic [DEPTH_LOG2:0] DEPTH_V = (DEPTH_LOG2 + 1)'(DEPTH);

   typedef enum logic [1:0] {
      MODE_ZERO  = 2'd0,
      MODE_FIXED = 2'd1,
      MODE_SEQ   = 2'd2,
      MODE_LFSR  = 2'd3
   } mode_t;

   logic [DATA_WIDTH-1:0]       pay_mem [DEPTH];
   logic [DELAY_WIDTH-1:0]      dly_cnt [DEPTH];
   logic [DELAY_WIDTH-1:0]      tbl_mem [TDEPTH];
   logic [DEPTH_LOG2-1:0]       head;
   logic [DEPTH_LOG2-1:0]       tail;
   logic [DEPTH_LOG2:0]         count;
   logic [TABLE_LOG2_DEPTH-1:0] wptr;
   logic [15:0]                 rptr;
   logic [15:0]                 rptr_nxt;
   logic                        run;
   logic [DEPTH_LOG2:0]         eff_lim;
   logic                        accept;
   logic                        pop;
   logic [DELAY_WIDTH-1:0]      new_dly;
   mode_t                       mode;

   assign mode = mode_t'(cfg_mode);

   always_comb begin
      eff_lim = cfg_max_outst;
      if (cfg_max_outst == '0 || cfg_max_outst > DEPTH_V)
         eff_lim = DEPTH_V;
   end

   // run keeps s_ready low during reset and releases it on the first edge afterwards
   assign s_ready     = run && (count < eff_lim);
   assign accept      = s_valid && s_ready;
   assign m_valid     = (count != '0) && (dly_cnt[head] == '0);
   assign m_data      = pay_mem[head];
   assign pop         = m_valid && m_ready;
   assign outstanding = count;

   always_comb begin
      new_dly = '0;
      case (mode)
         MODE_ZERO:  new_dly = '0;
         MODE_FIXED: new_dly = cfg_fixed_delay;
         default:    new_dly = tbl_mem[rptr[TABLE_LOG2_DEPTH-1:0]];
      endcase
   end

   // a seed reload takes priority over the advance caused by a coincident accept
   always_comb begin
      rptr_nxt = rptr;
      if (distr_rstptr) begin
         if (mode == MODE_LFSR && distr_seed == 16'h0000)
            rptr_nxt = 16'h0001;
         else
            rptr_nxt = distr_seed;
      end else if (accept && mode == MODE_SEQ) begin
         rptr_nxt = rptr + 16'd1;
      end else if (accept && mode == MODE_LFSR) begin
         rptr_nxt = {rptr[14:0], rptr[3] ^ rptr[12] ^ rptr[14] ^ rptr[15]};
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         wptr  <= '0;
         rptr  <= 16'h0001;
         run   <= 1'b0;
      end else begin
         run  <= 1'b1;
         rptr <= rptr_nxt;
         if (accept)
            tail <= tail + 1'b1;
         if (pop)
            head <= head + 1'b1;
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (distr_rstptr)
            wptr <= '0;
         else if (distr_write)
            wptr <= wptr + 1'b1;
      end
   end

   // storage is never reset; occupancy alone decides which entries are live
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (dly_cnt[i] != '0)
            dly_cnt[i] <= dly_cnt[i] - 1'b1;
      end
      if (accept) begin
         dly_cnt[tail] <= new_dly;
         pay_mem[tail] <= s_data;
      end
      if (distr_write)
         tbl_mem[wptr] <= distr_value;
   end

endmodule

// File: tb/tb_alg_amba_vip_base_delayline_prog.sv
// tb/tb_alg_amba_vip_base_delayline_prog.sv - randomized bench against a release-time queue model
// The model stores each beat with its absolute release cycle instead of a per-entry counter.
module tb_alg_amba_vip_base_delayline_prog;
   localparam int DW = 16;
   localparam int DL = 6;
   localparam int YW = 11;
   localparam int TL = 8;
   localparam int DEPTH = 1 << DL;
   localparam int TDEPTH = 1 << TL;

   logic          clk = 1'b0;
   logic          rstn;
   logic [1:0]    cfg_mode;
   logic [YW-1:0] cfg_fixed_delay;
   logic [DL:0]   cfg_max_outst;
   logic [YW-1:0] distr_value;
   logic          distr_write;
   logic          distr_rstptr;
   logic [15:0]   distr_seed;
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_ready;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready;
   logic [DL:0]   outstanding;

   int n_chk = 0;
   int n_bad = 0;

   logic [DW-1:0] q_data[$];
   int            q_rel[$];
   logic [YW-1:0] m_tbl[TDEPTH];
   int            m_wptr;
   logic [15:0]   m_rptr;
   int            now;
   bit            started;

   alg_amba_vip_base_delayline_prog #(
      .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .DELAY_WIDTH(YW), .TABLE_LOG2_DEPTH(TL)
   ) dut (
      .clk(clk), .rstn(rstn), .cfg_mode(cfg_mode), .cfg_fixed_delay(cfg_fixed_delay),
      .cfg_max_outst(cfg_max_outst), .distr_value(distr_value), .distr_write(distr_write),
      .distr_rstptr(distr_rstptr), .distr_seed(distr_seed), .s_valid(s_valid),
      .s_data(s_data), .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data),
      .m_ready(m_ready), .outstanding(outstanding)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int eff_lim();
      if (cfg_max_outst == 0 || int'(cfg_max_outst) > DEPTH) return DEPTH;
      return int'(cfg_max_outst);
   endfunction

   task automatic model_reset();
      q_data.delete();
      q_rel.delete();
      m_wptr  = 0;
      m_rptr  = 16'h0001;
      started = 1'b0;
   endtask

   task automatic idle();
      s_valid      = 1'b0;
      distr_write  = 1'b0;
      distr_rstptr = 1'b0;
      m_ready      = 1'b1;
   endtask

   // Called just after a falling edge with inputs already driven; returns after the next falling edge.
   task automatic step();
      logic exp_sr, exp_mv, acc, pop;
      int   d;
      #1;
      exp_sr = started && (q_data.size() < eff_lim());
      exp_mv = (q_data.size() > 0) && (q_rel[0] <= now);
      chk("s_ready", 32'(s_ready), 32'(exp_sr));
      chk("m_valid", 32'(m_valid), 32'(exp_mv));
      if (exp_mv) chk("m_data", 32'(m_data), 32'(q_data[0]));
      chk("outstanding", 32'(outstanding), 32'(q_data.size()));
      acc = s_valid && exp_sr;
      pop = exp_mv && m_ready;
      case (cfg_mode)
         2'd0:    d = 0;
         2'd1:    d = int'(cfg_fixed_delay);
         default: d = int'(m_tbl[m_rptr % TDEPTH]);
      endcase
      @(posedge clk);
      now++;
      started = 1'b1;
      if (pop) begin
         void'(q_data.pop_front());
         void'(q_rel.pop_front());
      end
      if (acc) begin
         q_data.push_back(s_data);
         q_rel.push_back(now + d);
      end
      if (distr_write) m_tbl[m_wptr] = distr_value;
      if (distr_rstptr) begin
         m_rptr = (cfg_mode == 2'd3 && distr_seed == 16'h0000) ? 16'h0001 : distr_seed;
         m_wptr = 0;
      end else begin
         if (distr_write) m_wptr = (m_wptr + 1) % TDEPTH;
         if (acc && cfg_mode == 2'd2) m_rptr = m_rptr + 16'd1;
         if (acc && cfg_mode == 2'd3)
            m_rptr = {m_rptr[14:0], m_rptr[3] ^ m_rptr[12] ^ m_rptr[14] ^ m_rptr[15]};
      end
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_s_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_outst"}, 32'(outstanding), 32'd0);
   endtask

   task automatic send(input logic [1:0] mode, input logic [15:0] data);
      cfg_mode = mode;
      s_valid  = 1'b1;
      s_data   = data;
      step();
      s_valid  = 1'b0;
   endtask

   task automatic drain(input int n);
      idle();
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic rand_phase(input int n, input int mode_sel);
      for (int i = 0; i < n; i++) begin
         cfg_mode = (mode_sel < 0) ? 2'($urandom_range(0, 3)) : 2'(mode_sel);
         if (i % 40 == 0) begin
            cfg_fixed_delay = YW'($urandom_range(0, 12));
            cfg_max_outst   = 7'($urandom_range(0, 9) == 0 ? $urandom_range(0, 127)
                                                           : $urandom_range(0, 8));
         end
         s_valid      = ($urandom_range(0, 3) != 0);
         s_data       = DW'($urandom);
         m_ready      = ($urandom_range(0, 3) != 0);
         distr_write  = ($urandom_range(0, 9) == 0);
         distr_value  = YW'($urandom_range(0, 9));
         distr_rstptr = ($urandom_range(0, 29) == 0);
         case ($urandom_range(0, 3))
            0:       distr_seed = 16'h0000;
            1:       distr_seed = 16'h8000;
            default: distr_seed = 16'($urandom);
         endcase
         step();
      end
      idle();
   endtask

   initial begin
      now = 0;
      model_reset();
      rstn            = 1'b0;
      cfg_mode        = 2'd0;
      cfg_fixed_delay = '0;
      cfg_max_outst   = '0;
      distr_value     = '0;
      distr_seed      = '0;
      s_data          = '0;
      idle();
      repeat (3) @(negedge clk);
      #1;
      check_reset_outputs("por");
      @(negedge clk);
      rstn = 1'b1;
      step();

      // load the table with small distinct-ish delays
      distr_rstptr = 1'b1;
      distr_seed   = 16'h0000;
      step();
      distr_rstptr = 1'b0;
      for (int i = 0; i < TDEPTH; i++) begin
         distr_write = 1'b1;
         distr_value = YW'(i % 13);
         step();
      end
      idle();

      // single fixed-delay beat
      cfg_fixed_delay = YW'(5);
      send(2'd1, 16'hA5A5);
      drain(8);

      // table {3,0,7}, back-to-back beats with head-of-line blocking
      cfg_mode     = 2'd2;
      distr_rstptr = 1'b1;
      distr_seed   = 16'h0000;
      step();
      distr_rstptr = 1'b0;
      foreach (m_tbl[i]) if (i < 3) begin
         distr_write = 1'b1;
         distr_value = (i == 0) ? YW'(3) : (i == 1) ? YW'(0) : YW'(7);
         step();
      end
      idle();
      send(2'd2, 16'hB000);
      send(2'd2, 16'hB001);
      send(2'd2, 16'hB002);
      drain(10);

      // outstanding limit with a stalled sink
      cfg_max_outst = 7'd4;
      cfg_mode      = 2'd0;
      m_ready       = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(16'hC000 + i);
         step();
      end
      s_valid = 1'b0;
      m_ready = 1'b1;
      for (int i = 0; i < 6; i++) step();
      cfg_max_outst = '0;

      // rstptr coincident with write at wptr=5, then read both slots back via delays
      distr_rstptr = 1'b1;
      distr_seed   = 16'h0000;
      step();
      distr_rstptr = 1'b0;
      for (int i = 0; i < 5; i++) begin
         distr_write = 1'b1;
         distr_value = YW'(2);
         step();
      end
      distr_value  = YW'(9);
      distr_rstptr = 1'b1;
      step();
      distr_rstptr = 1'b0;
      distr_value  = YW'(4);
      step();
      idle();
      cfg_mode     = 2'd2;
      distr_rstptr = 1'b1;
      distr_seed   = 16'h0005;
      step();
      idle();
      send(2'd2, 16'hD005);
      drain(12);
      distr_rstptr = 1'b1;
      distr_seed   = 16'h0000;
      step();
      idle();
      send(2'd2, 16'hD000);
      drain(8);

      // restore the index-valued table, then exercise LFSR seeds 0 and 0x8000
      distr_rstptr = 1'b1;
      distr_seed   = 16'h0000;
      step();
      distr_rstptr = 1'b0;
      for (int i = 0; i < 16; i++) begin
         distr_write = 1'b1;
         distr_value = YW'(i % 13);
         step();
      end
      idle();
      cfg_mode     = 2'd3;
      distr_rstptr = 1'b1;
      distr_seed   = 16'h0000;
      step();
      idle();
      send(2'd3, 16'hE001);
      send(2'd3, 16'hE002);
      drain(8);
      distr_rstptr = 1'b1;
      distr_seed   = 16'h8000;
      step();
      idle();
      send(2'd3, 16'hE800);
      send(2'd3, 16'hE801);
      drain(8);

      // randomized traffic per mode and with the mode changing every cycle
      for (int m = 0; m < 4; m++) begin
         rand_phase(400, m);
         drain(20);
      end
      rand_phase(600, -1);
      drain(20);

      // fill to DEPTH with long delays, then reset mid-delay
      cfg_mode        = 2'd1;
      cfg_fixed_delay = YW'(100);
      cfg_max_outst   = '0;
      m_ready         = 1'b1;
      for (int i = 0; i < DEPTH + 2; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(16'hF000 + i);
         step();
      end
      s_valid = 1'b0;
      for (int i = 0; i < 10; i++) step();
      #2;
      rstn = 1'b0;
      #1;
      model_reset();
      check_reset_outputs("mid");
      @(negedge clk);
      #1;
      check_reset_outputs("mid_hold");
      @(negedge clk);
      rstn = 1'b1;
      cfg_mode = 2'd0;
      for (int i = 0; i < 120; i++) step();
      rand_phase(300, -1);
      drain(40);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/alg_amba_vip_base_delayline_prog.md
ALG_AMBA_VIP_BASE_DELAYLINE_PROG -- requirements
Module: alg_amba_vip_base_delayline_prog

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width in bits.
REQ-002 SHALL have parameter DEPTH_LOG2, default 6, log2 of the number of storage entries (DEPTH = 2**DEPTH_LOG2).
REQ-003 SHALL have parameter DELAY_WIDTH, default 11, width of a per-beat delay value in cycles.
REQ-004 SHALL have parameter TABLE_LOG2_DEPTH, default 8, log2 of the delay-table depth.
REQ-005 SHALL have ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_mode  in  2  0=zero delay, 1=fixed delay, 2=table sequential, 3=table LFSR.
- cfg_fixed_delay  in  DELAY_WIDTH  delay used in mode 1.
- cfg_max_outst  in  DEPTH_LOG2+1  outstanding limit; 0 or >DEPTH means DEPTH.
- distr_value  in  DELAY_WIDTH  table write data.
- distr_write  in  1  write distr_value at table write pointer.
- distr_rstptr  in  1  clear write pointer, load read pointer from distr_seed.
- distr_seed  in  16  read-pointer/LFSR seed.
- s_valid / s_data / s_ready  in / in / out  1 / DATA_WIDTH / 1  input valid-ready stream.
- m_valid / m_data / m_ready  out / out / in  1 / DATA_WIDTH / 1  output valid-ready stream.
- outstanding  out  DEPTH_LOG2+1  number of stored beats.

Function
REQ-006 SHALL accept a beat on a clk edge with s_valid & s_ready, storing s_data and a delay counter in an in-order FIFO.
REQ-007 SHALL drive s_ready = (outstanding < effective limit); combinational, independent of m_ready (no push-on-full even if pop in same cycle).
REQ-008 SHALL select the stored delay at accept time: mode 0 -> 0; mode 1 -> cfg_fixed_delay; mode 2/3 -> table[rptr[TABLE_LOG2_DEPTH-1:0]].
REQ-009 SHALL decrement every stored nonzero delay counter by 1 on each edge after accept, saturating at 0.
REQ-010 SHALL drive m_valid = FIFO non-empty & head counter == 0; m_data = head payload; pop on m_valid & m_ready.
REQ-011 SHALL give latency: beat accepted at edge T with delay d shows m_valid from the cycle after edge T+d (d=0 -> next cycle), absent head-of-line blocking.
REQ-012 SHALL release strictly in acceptance order; a younger expired beat waits behind an unexpired head.
REQ-013 SHALL keep m_valid and m_data stable while m_valid & !m_ready.
REQ-014 SHALL update outstanding: +1 on accept, -1 on pop, unchanged on both; range 0..DEPTH.
REQ-015 SHALL advance the table read pointer only on accept in mode 2 (rptr+1, wrapping modulo 2**TABLE_LOG2_DEPTH in the index bits) or mode 3 (16-bit LFSR: rptr <= {rptr[14:0], rptr[3]^rptr[12]^rptr[14]^rptr[15]}).
REQ-016 SHALL on distr_rstptr load rptr with distr_seed, except seed 0 in mode 3 loads 16'h0001; wptr <= 0.
REQ-017 SHALL on distr_write store distr_value at table[wptr] and increment wptr with wrap at 2**TABLE_LOG2_DEPTH.
REQ-018 SHALL, when distr_rstptr and distr_write coincide, write at the old wptr and end with wptr = 0.
REQ-019 SHALL, when distr_rstptr and an accept coincide, use the old rptr for the accepted beat and end with rptr loaded per REQ-016.
REQ-020 SHALL, when distr_write and a table read hit the same index in one cycle, return the old contents.
REQ-021 SHALL apply cfg_mode / cfg_fixed_delay changes to the next accepted beat only; stored beats keep their counters.
REQ-022 SHALL, when cfg_max_outst is lowered below outstanding, hold s_ready low until outstanding drops below it; no stored beat dropped.

Reset
REQ-023 SHALL on rstn low asynchronously clear FIFO pointers, outstanding=0, m_valid=0, s_ready=0 while asserted, wptr=0, rptr=16'h0001.
REQ-024 SHALL not reset table contents or payload storage; mid-operation reset discards all stored beats.
REQ-025 SHALL assert s_ready on the first edge after rstn release (outstanding=0).

Verification
REQ-026 Mode 1, cfg_fixed_delay=5, one beat 0xA5A5 accepted at edge T, m_ready=1 -> m_valid high only in cycle after edge T+5, data 0xA5A5.
REQ-027 Mode 2, table {3,0,7} written after distr_rstptr seed 0, beats B0..B2 back-to-back -> B0 out after 3, B1 immediately after B0 (head blocking), B2 at accept+7.
REQ-028 Mode 0, cfg_max_outst=4, m_ready=0, s_valid held -> exactly 4 accepts, s_ready low, outstanding=4; m_ready=1 -> 4 beats in order, one per cycle.
REQ-029 Mode 3, seed 16'h0000 -> rptr loaded 16'h0001, next accept leaves rptr=16'h0002; seed 16'h8000 -> next rptr 16'h0001.
REQ-030 Fill DEPTH=64 beats with delay 100, assert rstn low mid-delay -> m_valid=0, outstanding=0 immediately; after release s_ready=1, no old beat emitted.
REQ-031 distr_rstptr with distr_write (value 9) at wptr=5 -> table[5]=9, wptr=0; next write lands at index 0.
